// File: rtl/bcd_mode_counter_if.sv
// bcd_mode_counter_if
//   Bus bundle for bcd_mode_counter. Control inputs (en, mode, step,
//   load_val) flow master -> slave; the count, wrap pulse and the
//   converted BCD / 7-segment display values flow slave -> master.
//   DIGITS  : number of BCD / 7-seg digits
//   MODULUS : count range 0..MODULUS-1
//   STEP_W  : width of the step input
interface bcd_mode_counter_if #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 100,
   parameter int STEP_W  = 4
);
   localparam int CW = $clog2(MODULUS);

   logic                  en;
   logic [1:0]            mode;
   logic [STEP_W-1:0]     step;
   logic [CW-1:0]         load_val;
   logic [CW-1:0]         count;
   logic                  wrap;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   hex;
   logic                  cvt_busy;

   modport master (
      output en, mode, step, load_val,
      input  count, wrap, bcd, hex, cvt_busy
   );

   modport slave (
      input  en, mode, step, load_val,
      output count, wrap, bcd, hex, cvt_busy
   );
endinterface

// File: rtl/bcd_mode_counter.sv
// bcd_mode_counter
//   Modulo up/down/load counter with a variable step, followed by a
//   sequential shift-and-add-3 binary-to-BCD converter and an active-low
//   7-segment decoder per digit.
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   bus.en       : count qualifier (hold when low)
//   bus.mode     : 00 hold, 01 up, 10 down, 11 load
//   bus.step     : step amount, saturated to MODULUS-1
//   bus.load_val : value taken on load (out of range loads 0)
//   bus.count    : binary count
//   bus.wrap     : one-cycle pulse after an up/down edge that wrapped
//   bus.bcd      : converted count, digit 0 in [3:0]
//   bus.hex      : active-low {g..a} per digit, digit 0 in [6:0]
//   bus.cvt_busy : converter in SHIFT or DONE
module bcd_mode_counter #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 100,
   parameter int STEP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   bcd_mode_counter_if.slave bus
);
   localparam int CW    = $clog2(MODULUS);
   localparam int BW    = 4 * DIGITS;
   localparam int HW    = 7 * DIGITS;
   localparam int CNT_W = $clog2(CW + 1);

   localparam logic [CW:0]   MOD_X   = (CW+1)'(MODULUS);
   localparam logic [CW-1:0] MAX_S   = CW'(MODULUS - 1);
   localparam logic [HW-1:0] HEX_RST = {DIGITS{7'b1000000}};

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} cvt_state_e;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // ---------------------------------------------------------------
   // Counter
   // ---------------------------------------------------------------
   logic [CW-1:0] count_q, count_d;
   logic          wrap_q, wrap_d;
   logic [CW-1:0] s_eff;
   logic [CW:0]   sum, sum_m, dn_wrap;

   always_comb begin
      if (32'(bus.step) > 32'(MODULUS - 1)) s_eff = MAX_S;
      else                                  s_eff = CW'(bus.step);

      // One extra bit so count+s and count+MODULUS-s never overflow.
      sum     = {1'b0, count_q} + {1'b0, s_eff};
      sum_m   = sum - MOD_X;
      dn_wrap = {1'b0, count_q} + MOD_X - {1'b0, s_eff};

      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            2'b01: begin
               if (sum >= MOD_X) begin
                  count_d = sum_m[CW-1:0];
                  wrap_d  = 1'b1;
               end else begin
                  count_d = sum[CW-1:0];
               end
            end
            2'b10: begin
               if (count_q >= s_eff) begin
                  count_d = count_q - s_eff;
               end else begin
                  count_d = dn_wrap[CW-1:0];
                  wrap_d  = 1'b1;
               end
            end
            2'b11: count_d = ({1'b0, bus.load_val} < MOD_X) ? bus.load_val : '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // ---------------------------------------------------------------
   // Binary-to-BCD converter
   // shadow holds the last value fully converted; a mismatch with count
   // in IDLE starts a new pass. cap holds the value being converted so
   // the display only ever shows something count really held.
   // ---------------------------------------------------------------
   cvt_state_e       state_q, state_d;
   logic [CW-1:0]    shadow_q, shadow_d;
   logic [CW-1:0]    cap_q, cap_d;
   logic [CW-1:0]    sreg_q, sreg_d;
   logic [BW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [HW-1:0]    hex_q, hex_d;
   logic [BW-1:0]    adj;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cap_d    = cap_q;
      sreg_d   = sreg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      hex_d    = hex_q;
      adj      = acc_q;

      case (state_q)
         S_IDLE: begin
            if (count_q != shadow_q) begin
               cap_d   = count_q;
               sreg_d  = count_q;
               acc_d   = '0;
               cnt_d   = CNT_W'(CW);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
            {acc_d, sreg_d} = {adj[BW-2:0], sreg_q, 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d = acc_q;
            for (int i = 0; i < DIGITS; i++) hex_d[7*i +: 7] = seg7(acc_q[4*i +: 4]);
            shadow_d = cap_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         cap_q    <= '0;
         sreg_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         hex_q    <= HEX_RST;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cap_q    <= cap_d;
         sreg_q   <= sreg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         hex_q    <= hex_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.wrap     = wrap_q;
   assign bus.bcd      = bcd_q;
   assign bus.hex      = hex_q;
   assign bus.cvt_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_bcd_mode_counter.sv
// tb_bcd_mode_counter
//   Directed bench: a vector table for the counter datapath on the
//   2-digit / mod-100 instance, then hand sequences for reset, conversion
//   latency, display consistency and the 1-digit / mod-10 instance.
module tb_bcd_mode_counter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_mode_counter_if #(.DIGITS(2), .MODULUS(100), .STEP_W(4)) ia();
   bcd_mode_counter_if #(.DIGITS(1), .MODULUS(10),  .STEP_W(4)) ib();

   bcd_mode_counter #(.DIGITS(2), .MODULUS(100), .STEP_W(4)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   bcd_mode_counter #(.DIGITS(1), .MODULUS(10), .STEP_W(4)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

   localparam logic [6:0] SEG0 = 7'b1000000;
   localparam logic [6:0] SEG2 = 7'b0100100;
   localparam logic [6:0] SEG3 = 7'b0110000;
   localparam logic [6:0] SEG5 = 7'b0010010;
   localparam logic [6:0] SEG7 = 7'b1111000;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic [3:0] step;
      logic [6:0] lv;
      logic [6:0] exp_cnt;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive_a(input logic en, input logic [1:0] m, input logic [3:0] s, input logic [6:0] lv);
      ia.en = en; ia.mode = m; ia.step = s; ia.load_val = lv;
   endtask

   task automatic drive_b(input logic en, input logic [1:0] m, input logic [3:0] s, input logic [3:0] lv);
      ib.en = en; ib.mode = m; ib.step = s; ib.load_val = lv;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic ok;
      //            en    mode   step   load    count   wrap
      vecs[0]  = '{1'b1, 2'b11, 4'd0,  7'd95,  7'd95, 1'b0};
      vecs[1]  = '{1'b1, 2'b01, 4'd7,  7'd0,   7'd2,  1'b1};
      vecs[2]  = '{1'b1, 2'b00, 4'd7,  7'd0,   7'd2,  1'b0};
      vecs[3]  = '{1'b1, 2'b11, 4'd0,  7'd1,   7'd1,  1'b0};
      vecs[4]  = '{1'b1, 2'b10, 4'd3,  7'd0,   7'd98, 1'b1};
      vecs[5]  = '{1'b1, 2'b10, 4'd0,  7'd0,   7'd98, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 4'd15, 7'd0,   7'd98, 1'b0};
      vecs[7]  = '{1'b1, 2'b01, 4'd15, 7'd0,   7'd13, 1'b1};
      vecs[8]  = '{1'b1, 2'b10, 4'd15, 7'd0,   7'd98, 1'b1};
      vecs[9]  = '{1'b1, 2'b11, 4'd0,  7'd120, 7'd0,  1'b0};
      vecs[10] = '{1'b1, 2'b10, 4'd1,  7'd0,   7'd99, 1'b1};
      vecs[11] = '{1'b1, 2'b01, 4'd1,  7'd0,   7'd0,  1'b1};
      vecs[12] = '{1'b1, 2'b01, 4'd9,  7'd0,   7'd9,  1'b0};
      vecs[13] = '{1'b1, 2'b10, 4'd9,  7'd0,   7'd0,  1'b0};
      vecs[14] = '{1'b1, 2'b11, 4'd0,  7'd99,  7'd99, 1'b0};
      vecs[15] = '{1'b1, 2'b01, 4'd0,  7'd0,   7'd99, 1'b0};
      vecs[16] = '{1'b1, 2'b01, 4'd1,  7'd0,   7'd0,  1'b1};
      vecs[17] = '{1'b0, 2'b10, 4'd5,  7'd0,   7'd0,  1'b0};

      rst = 1'b1;
      drive_a(1'b0, 2'b00, 4'd0, 7'd0);
      drive_b(1'b0, 2'b00, 4'd0, 4'd0);
      #12;
      chk("rst_count",   32'(ia.count),    32'd0);
      chk("rst_wrap",    32'(ia.wrap),     32'd0);
      chk("rst_bcd",     32'(ia.bcd),      32'd0);
      chk("rst_hex",     32'(ia.hex),      32'({SEG0, SEG0}));
      chk("rst_busy",    32'(ia.cvt_busy), 32'd0);
      chk("rst_b_hex",   32'(ib.hex),      32'(SEG0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_after_rst", 32'(ia.cvt_busy), 32'd0);

      // Counter datapath table.
      foreach (vecs[i]) begin
         drive_a(vecs[i].en, vecs[i].mode, vecs[i].step, vecs[i].lv);
         tick();
         chk($sformatf("vec%0d_count", i), 32'(ia.count), 32'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d_wrap",  i), 32'(ia.wrap),  32'(vecs[i].exp_wrap));
      end

      // Up-wrap to 2, then display of 02 nine cycles later.
      drive_a(1'b1, 2'b11, 4'd0, 7'd95);
      tick();
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      repeat (20) tick();
      chk("disp95", 32'(ia.bcd), 32'h95);
      drive_a(1'b1, 2'b01, 4'd7, 7'd0);
      tick();
      chk("up7_count", 32'(ia.count), 32'd2);
      chk("up7_wrap",  32'(ia.wrap),  32'd1);
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      tick();
      chk("up7_wrap_clr", 32'(ia.wrap), 32'd0);
      repeat (8) tick();
      chk("disp02_bcd", 32'(ia.bcd), 32'h02);
      chk("disp02_hex", 32'(ia.hex), 32'({SEG0, SEG2}));

      // Conversion latency for a load of 57.
      drive_a(1'b1, 2'b11, 4'd0, 7'd57);
      tick();
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      chk("lat_busy_n0", 32'(ia.cvt_busy), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("lat_busy_n%0d", k), 32'(ia.cvt_busy), 32'd1);
      end
      tick();
      chk("lat_busy_n9", 32'(ia.cvt_busy), 32'd0);
      chk("lat_bcd57",   32'(ia.bcd),      32'h57);
      chk("lat_hex57",   32'(ia.hex),      32'({SEG5, SEG7}));

      // Three rapid increments: display never shows 12.
      drive_a(1'b1, 2'b11, 4'd0, 7'd10);
      tick();
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      repeat (20) tick();
      chk("disp10", 32'(ia.bcd), 32'h10);
      drive_a(1'b1, 2'b01, 4'd1, 7'd0);
      repeat (3) tick();
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      chk("burst_count", 32'(ia.count), 32'd13);
      for (int k = 0; k < 20; k++) begin
         tick();
         ok = (ia.bcd == 8'h10) || (ia.bcd == 8'h11) || (ia.bcd == 8'h13);
         chk($sformatf("burst_legal%0d", k), 32'(ok), 32'd1);
      end
      chk("burst_final", 32'(ia.bcd), 32'h13);

      // Single-digit mod-10 instance: saturated step and out-of-range load.
      drive_b(1'b1, 2'b11, 4'd0, 4'd3);
      tick();
      drive_b(1'b1, 2'b01, 4'd15, 4'd0);
      tick();
      chk("b_up_count", 32'(ib.count), 32'd2);
      chk("b_up_wrap",  32'(ib.wrap),  32'd1);
      drive_b(1'b1, 2'b11, 4'd0, 4'd12);
      tick();
      chk("b_load_count", 32'(ib.count), 32'd0);
      chk("b_load_wrap",  32'(ib.wrap),  32'd0);
      drive_b(1'b0, 2'b00, 4'd0, 4'd0);
      repeat (4) tick();
      chk("b_disp3_bcd", 32'(ib.bcd), 32'h3);
      chk("b_disp3_hex", 32'(ib.hex), 32'(SEG3));
      repeat (6) tick();
      chk("b_disp0_bcd", 32'(ib.bcd), 32'h0);
      chk("b_disp0_hex", 32'(ib.hex), 32'(SEG0));

      // Reset in the middle of a conversion.
      drive_a(1'b1, 2'b11, 4'd0, 7'd42);
      tick();
      drive_a(1'b1, 2'b00, 4'd0, 7'd0);
      repeat (2) tick();
      chk("mid_count", 32'(ia.count),    32'd42);
      chk("mid_busy",  32'(ia.cvt_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(ia.count),    32'd0);
      chk("mid_rst_busy",  32'(ia.cvt_busy), 32'd0);
      chk("mid_rst_hex",   32'(ia.hex),      32'({SEG0, SEG0}));
      chk("mid_rst_bcd",   32'(ia.bcd),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_busy",  32'(ia.cvt_busy), 32'd0);
      chk("post_rst_count", 32'(ia.count),    32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
